// File: rtl/serial_adder4_if.sv
// Handshake/operand bundle for serial_adder4.
// The overflow signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             overflow;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );
    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );
`else
    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out
    );
    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out
    );
`endif
endinterface

// File: rtl/serial_adder4.sv
// Bit-serial ripple adder: one full-adder cell, one operand bit per clock,
// LSB first. Result {carry_out,sum} = a + b + carry_in, presented with a
// one-cycle done pulse. Optional signed overflow output: SERIAL_ADDER_OVF_EN.
module serial_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder4_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             c_q;
    logic [WIDTH-2:0] sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] sh_d;
    logic             accept;

    // Full-adder cell on the current LSBs; the shadow holds the WIDTH-1 sum
    // bits produced so far, so sh_d is the complete sum on the final bit.
    always_comb begin
        s_d    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        sh_d   = {s_d, sh_q};
        accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            sh_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    c_q    <= c_d;
                    sh_q   <= sh_d[WIDTH-1:1];
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sh_d;
                        cout_q  <= c_d;
`ifdef SERIAL_ADDER_OVF_EN
                        // c_q is the carry into the MSB at this point
                        ovf_q   <= c_q ^ c_d;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase

            // Accept from IDLE or DONE overrides the state chosen above
            if (accept) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                a_sh_q  <= bus.a;
                b_sh_q  <= bus.b;
                c_q     <= bus.carry_in;
                sh_q    <= '0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.overflow  = ovf_q;
`endif

endmodule

// File: doc/serial_adder4.md
Name: serial_adder4

Overview:
- Bit-serial ripple adder: the multi-cycle addition counterpart to the team's combinational 4-bit borrow-chain subtractor.
- Latches two WIDTH-bit operands and a carry-in on a start pulse.
- Adds one bit per clock, LSB first, through a single full-adder cell.
- Returns sum and carry-out with a one-cycle done pulse. Used in area-constrained datapaths where a WIDTH-wide adder is not affordable.

Parameters:
- WIDTH, 4, operand/sum width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is not busy
- a  input  WIDTH  operand A, unsigned (two's complement when OVF feature is used)
- b  input  WIDTH  operand B
- carry_in  input  1  initial carry into bit 0
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum/carry_out are valid from this cycle
- sum  output  WIDTH  result bits a+b+carry_in modulo 2^WIDTH
- carry_out  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). No asynchronous reset path.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, bit counter=0, internal operand/carry registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b and carry_in into shift/carry registers, clears the counter and goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge computes s = a_sh[0]^b_sh[0]^c and c' = majority(a_sh[0], b_sh[0], c).
  - s shifts into the MSB of the sum shift register (right shift); a_sh and b_sh shift right; the counter increments.
  - At the edge where counter==WIDTH-1, the last bit is processed and the state goes to DONE.
- DONE:
  - Lasts exactly one cycle. done=1; sum and carry_out present the final result.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accept, operands latched as in IDLE).
- Latency: start sampled at edge 0 -> busy=1 during cycles 1..WIDTH -> done=1 in cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- busy=1 exactly when state==RUN. start while busy is ignored; it does not queue and does not corrupt the operation.
- Input stability: a, b and carry_in are only sampled at the accepting edge and may change afterward.
- sum, carry_out and overflow hold their last result until the next DONE. They do not change during RUN, which uses an internal shadow register; outputs load when entering DONE.
- Arithmetic: full result is {carry_out,sum} = a + b + carry_in, with no truncation beyond WIDTH+1 bits.
  - Wrap-around example: 4'hF + 4'h0 + 1 = sum 0, carry_out 1.
- Reset mid-operation: rst=1 at any edge forces IDLE and all reset values. rst wins over start at the same edge, and the in-flight result is discarded.
- Counter width is $clog2(WIDTH); no X propagation from unused counter values.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - The overflow port exists. overflow = carry into MSB XOR carry out of MSB, captured at the final RUN bit and updated with sum on DONE.
  - overflow resets to 0 and holds between operations.
- Undefined: the overflow port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a=8, b=5, carry_in=0, start for 1 cycle -> busy high 4 cycles; done in cycle 5 with sum=13, carry_out=0.
- a=12, b=6, carry_in=1 -> sum=3, carry_out=1 (19 mod 16); with OVF_EN, overflow=0 (-4+6+1=3).
- a=7, b=1, carry_in=0 with SERIAL_ADDER_OVF_EN -> sum=8, carry_out=0, overflow=1. Also a=15, b=0, carry_in=1 -> sum=0, carry_out=1.
- start pulsed again in cycle 2 of RUN with different operands -> ignored; result equals the first operation; done pulses once.
- start held high through DONE with new operands 3+8 -> first done pulse, then busy resumes next cycle; second done gives sum=11, carry_out=0.
- rst asserted in cycle 3 of RUN -> next cycle busy=0, done=0, sum=0, carry_out=0. No done pulse follows. A new start afterwards completes normally.
